// File: rtl/addr_decode_router.sv
//------------------------------------------------------------------------------
// addr_decode_router
//
// Responder-side decoder for the 27-bit generic address (addr_t). It accepts
// one request per cycle and splits the address into its fields. Each request
// goes either to the downstream target channel (tgt_*) or, when the address is
// unmapped, to the decode-error channel (err_*).
//
// The output is a single registered slot, so latency is exactly one cycle.
// The slot can pop and refill in the same cycle, which keeps full throughput.
// No combinational path runs from req_* to tgt_*/err_*.
//
// Address layout (addr_t, 27 bits):
//   ZAP     : [26]=1, [25]=is_csr, [24:19]=zap_id ({rack_id[2:0], zap[2:0]})
//             MEM : [18:0]  offset
//             CSR : [18:15] zap_block_id, [14:0] offset
//   non-ZAP : [26]=0, [25:23]=non_zap_block_id
//             RACK (id 6): [22:20] rack_id, [19:18] rack_block_id,
//                          [17:15] instance, [14:0] offset
//             others     : [22:0] offset
//
// Parameters:
//   ADDR_WIDTH    - request address width (27, fixed by the address layout)
//   DATA_WIDTH    - write data width
//   LOCAL_RACK_ID - rack ID of this rack; other racks decode as REMOTE
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_ready            - request handshake
//   req_addr, req_write, req_wdata - request payload
//   tgt_valid/tgt_ready            - decoded request handshake
//   tgt_class                      - 0 ZAP_MEM, 1 ZAP_CSR, 2 NON_ZAP,
//                                    3 RACK_BLK, 4 REMOTE
//   tgt_zap_id, tgt_block_id, tgt_inst_id, tgt_offset - decoded fields
//   tgt_write, tgt_wdata           - registered request write/data
//   err_valid/err_ready            - decode-error response handshake
//   err_addr                       - offending address
//
// Optional feature (macro ADDR_DECODE_ERR_CNT_EN):
//   err_cnt     - 16-bit saturating count of err_valid & err_ready handshakes
//   err_cnt_clr - zeroes err_cnt on the next cycle; a clear wins over an
//                 increment in the same cycle
//------------------------------------------------------------------------------
module addr_decode_router #(
  parameter int         ADDR_WIDTH    = 27,
  parameter int         DATA_WIDTH    = 32,
  parameter logic [2:0] LOCAL_RACK_ID = 3'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // target side
  output logic                  tgt_valid,
  input  logic                  tgt_ready,
  output logic [2:0]            tgt_class,
  output logic [5:0]            tgt_zap_id,
  output logic [3:0]            tgt_block_id,
  output logic [2:0]            tgt_inst_id,
  output logic [22:0]           tgt_offset,
  output logic                  tgt_write,
  output logic [DATA_WIDTH-1:0] tgt_wdata,
  // error side
  output logic                  err_valid,
  input  logic                  err_ready,
  output logic [ADDR_WIDTH-1:0] err_addr
`ifdef ADDR_DECODE_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt,
  input  logic                  err_cnt_clr
`endif
);

  // Target classes
  localparam logic [2:0] CLS_ZAP_MEM  = 3'd0;
  localparam logic [2:0] CLS_ZAP_CSR  = 3'd1;
  localparam logic [2:0] CLS_NON_ZAP  = 3'd2;
  localparam logic [2:0] CLS_RACK_BLK = 3'd3;
  localparam logic [2:0] CLS_REMOTE   = 3'd4;

  // Non-ZAP block IDs with special handling
  localparam logic [2:0] NZB_RESERVED = 3'd3;
  localparam logic [2:0] NZB_RACK     = 3'd6;

  // Rack block IDs with special handling. ICE exists only as instance 0.
  localparam logic [1:0] RBID_ICE      = 2'd0;
  localparam logic [1:0] RBID_RESERVED = 2'd3;

  // ZAP CSR block IDs 0, 13, 14 and 15 are unmapped. Bit n set = block n illegal.
  localparam logic [15:0] CSR_BLK_ILLEGAL = 16'hE001;

  //--------------------------------------------------------------------------
  // Address field extraction
  //--------------------------------------------------------------------------
  logic       a_is_zap;
  logic       a_is_csr;
  logic [5:0] a_zap_id;
  logic [3:0] a_zap_blk;
  logic [2:0] a_nzb_id;
  logic [2:0] a_rack_id_nz;
  logic [1:0] a_rack_blk;
  logic [2:0] a_inst;

  assign a_is_zap     = req_addr[26];
  assign a_is_csr     = req_addr[25];
  assign a_zap_id     = req_addr[24:19];
  assign a_zap_blk    = req_addr[18:15];
  assign a_nzb_id     = req_addr[25:23];
  assign a_rack_id_nz = req_addr[22:20];
  assign a_rack_blk   = req_addr[19:18];
  assign a_inst       = req_addr[17:15];

  //--------------------------------------------------------------------------
  // Combinational decode of the incoming request
  //--------------------------------------------------------------------------
  logic        dec_err;
  logic [2:0]  dec_class;
  logic [5:0]  dec_zap_id;
  logic [3:0]  dec_block_id;
  logic [2:0]  dec_inst_id;
  logic [22:0] dec_offset;
  logic [2:0]  dec_rack_id;
  logic        dec_has_rack;

  always_comb begin
    dec_err      = 1'b0;
    dec_class    = CLS_NON_ZAP;
    dec_zap_id   = 6'd0;
    dec_block_id = 4'd0;
    dec_inst_id  = 3'd0;
    dec_offset   = 23'd0;
    dec_rack_id  = 3'd0;
    dec_has_rack = 1'b0;

    if (a_is_zap) begin
      // The upper three bits of zap_id are the rack.
      dec_zap_id   = a_zap_id;
      dec_rack_id  = a_zap_id[5:3];
      dec_has_rack = 1'b1;
      if (a_is_csr) begin
        dec_class    = CLS_ZAP_CSR;
        dec_block_id = a_zap_blk;
        dec_offset   = {8'd0, req_addr[14:0]};
        dec_err      = CSR_BLK_ILLEGAL[a_zap_blk];
      end else begin
        dec_class  = CLS_ZAP_MEM;
        dec_offset = {4'd0, req_addr[18:0]};
      end
    end else if (a_nzb_id == NZB_RACK) begin
      dec_class    = CLS_RACK_BLK;
      dec_block_id = {2'd0, a_rack_blk};
      dec_inst_id  = a_inst;
      dec_offset   = {8'd0, req_addr[14:0]};
      dec_rack_id  = a_rack_id_nz;
      dec_has_rack = 1'b1;
      dec_err      = (a_rack_blk == RBID_RESERVED) ||
                     ((a_rack_blk == RBID_ICE) && (a_inst != 3'd0));
    end else begin
      dec_class    = CLS_NON_ZAP;
      dec_block_id = {1'b0, a_nzb_id};
      dec_offset   = req_addr[22:0];
      dec_err      = (a_nzb_id == NZB_RESERVED);
    end

    // A decode error always wins. Only addresses that carry a rack ID can
    // be REMOTE.
    if (!dec_err && dec_has_rack && (dec_rack_id != LOCAL_RACK_ID)) begin
      dec_class = CLS_REMOTE;
    end
  end

  //--------------------------------------------------------------------------
  // One-entry output slot
  //--------------------------------------------------------------------------
  logic                  tgt_valid_reg;
  logic                  err_valid_reg;
  logic [2:0]            class_reg;
  logic [5:0]            zap_id_reg;
  logic [3:0]            block_id_reg;
  logic [2:0]            inst_id_reg;
  logic [22:0]           offset_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [ADDR_WIDTH-1:0] err_addr_reg;

  logic slot_full;
  logic slot_pop;
  logic accept;

  assign slot_full = tgt_valid_reg | err_valid_reg;
  assign slot_pop  = (tgt_valid_reg & tgt_ready) | (err_valid_reg & err_ready);
  // Gating with rst keeps the input closed while reset is held, including
  // the cycles before the first reset edge has cleared the slot.
  assign req_ready = ~rst & (~slot_full | slot_pop);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_valid_reg <= 1'b0;
      err_valid_reg <= 1'b0;
      class_reg     <= 3'd0;
      zap_id_reg    <= 6'd0;
      block_id_reg  <= 4'd0;
      inst_id_reg   <= 3'd0;
      offset_reg    <= 23'd0;
      write_reg     <= 1'b0;
      wdata_reg     <= '0;
      err_addr_reg  <= '0;
    end else if (accept) begin
      // A push that coincides with a pop overwrites the slot, so no bubble
      // appears.
      tgt_valid_reg <= ~dec_err;
      err_valid_reg <= dec_err;
      class_reg     <= dec_class;
      zap_id_reg    <= dec_zap_id;
      block_id_reg  <= dec_block_id;
      inst_id_reg   <= dec_inst_id;
      offset_reg    <= dec_offset;
      write_reg     <= req_write;
      wdata_reg     <= req_wdata;
      err_addr_reg  <= req_addr;
    end else if (slot_pop) begin
      tgt_valid_reg <= 1'b0;
      err_valid_reg <= 1'b0;
    end
  end

  assign tgt_valid    = tgt_valid_reg;
  assign err_valid    = err_valid_reg;
  assign tgt_class    = class_reg;
  assign tgt_zap_id   = zap_id_reg;
  assign tgt_block_id = block_id_reg;
  assign tgt_inst_id  = inst_id_reg;
  assign tgt_offset   = offset_reg;
  assign tgt_write    = write_reg;
  assign tgt_wdata    = wdata_reg;
  assign err_addr     = err_addr_reg;

`ifdef ADDR_DECODE_ERR_CNT_EN
  //--------------------------------------------------------------------------
  // Saturating decode-error counter
  //--------------------------------------------------------------------------
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= 16'd0;
    end else if (err_cnt_clr) begin
      err_cnt_reg <= 16'd0;
    end else if (err_valid_reg && err_ready && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: doc/addr_decode_router.md
Name: addr_decode_router

Overview:
- Responder-side decoder for the 27-bit generic address (addr_t) built by initiators.
- Accepts one request per cycle on a valid/ready input and splits the address into its fields: is_zap, ZAP/non-ZAP block IDs, rack/zap/instance IDs and offset.
- Routes each request to one downstream target channel, or to an error response channel when the address is unmapped.
- Sits at the entry of each rack's CSR/memory fabric.

Parameters:
- ADDR_WIDTH, 27, request address width; fixed by the address schema.
- DATA_WIDTH, 32, write data width.
- LOCAL_RACK_ID, 0, 3-bit ID of this rack. A request whose rack_id differs is classed REMOTE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_addr  in  27  addr_t
- req_write  in  1  1=write, 0=read
- req_wdata  in  DATA_WIDTH  write data
- tgt_valid  out  1  decoded request valid
- tgt_ready  in  1  downstream ready
- tgt_class  out  3  0 ZAP_MEM, 1 ZAP_CSR, 2 NON_ZAP, 3 RACK_BLK, 4 REMOTE
- tgt_zap_id  out  6  {rack_id, zap_id}; 0 when not a ZAP request
- tgt_block_id  out  4  zap_block_id, non_zap_block_id or rack_block_id, zero-extended
- tgt_inst_id  out  3  rack_block_inst_id; 0 otherwise
- tgt_offset  out  23  offset, zero-extended
- tgt_write  out  1  registered req_write
- tgt_wdata  out  DATA_WIDTH  registered req_wdata
- err_valid  out  1  decode-error response valid
- err_ready  in  1  error consumer ready
- err_addr  out  27  offending address

Behaviour:
- Decode fields:
  - is_zap = addr[26].
  - ZAP requests: is_csr = addr[25], zap_id = addr[24:19].
    - MEM (is_csr=0): offset = addr[18:0].
    - CSR (is_csr=1): zap_block_id = addr[18:15], offset = addr[14:0].
  - Non-ZAP requests: non_zap_block_id = addr[25:23].
    - RACK block (ID 6): rack_id = addr[22:20], rack_block_id = addr[19:18], inst = addr[17:15], offset = addr[14:0].
    - All other IDs: offset = addr[22:0].
- Error conditions, in order:
  - ZAP CSR with zap_block_id in {0, 13, 14, 15}.
  - non_zap_block_id == 3.
  - RACK block with rack_block_id == 3.
  - RACK block targeting ICE with inst != 0.
- REMOTE: a valid address whose rack_id (addr[24:22] for ZAP, addr[22:20] for RACK) != LOCAL_RACK_ID. Other non-ZAP blocks have no rack_id and are never REMOTE.
- Error takes precedence over REMOTE.
- Single output slot (one-entry register):
  - req_ready = !slot_full | (tgt_valid & tgt_ready) | (err_valid & err_ready).
  - Accept happens on req_valid & req_ready.
  - Latency is exactly 1 cycle: request accepted in cycle N gives tgt_valid or err_valid high in cycle N+1.
  - Full throughput when both consumers are always ready.
- tgt_valid and err_valid are never both high.
- Output fields stay stable while valid is high and ready is low; no combinational path from req_* to tgt_*/err_*.
- Requests leave in acceptance order. An error entry blocks later requests until err_ready.
- A simultaneous pop and push in the same cycle replaces the slot content without a bubble.
- Reset:
  - req_ready = 0 during reset, 1 in the first cycle after reset.
  - tgt_valid = 0, err_valid = 0, all data outputs 0.
  - Reset mid-operation drops the held entry; nothing is replayed.

Optional Feature:
- Macro ADDR_DECODE_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt (16 bits) and input err_cnt_clr.
  - err_cnt increments on each err_valid & err_ready handshake and saturates at 0xFFFF.
  - err_cnt_clr zeroes it next cycle. A clear wins over a simultaneous increment.
  - Reset value is 0.
- When undefined: no ports, no logic.

Test Plan:
- LOCAL_RACK_ID=2, addr 0x6A98123 (ZAP CSR, zap_id 21, EYE, offset 0x123), both readies high → cycle N+1: tgt_valid=1, tgt_class=1, tgt_zap_id=21, tgt_block_id=3, tgt_offset=0x123.
- addr 0x1800000 (non_zap_block_id 3) → err_valid=1, err_addr=0x1800000, tgt_valid stays 0. With ADDR_DECODE_ERR_CNT_EN, err_cnt=1 after the handshake.
- addr 0x3208000 (RACK, rack 2, ICE inst 1) → error. addr 0x3200000 → tgt_class=3, tgt_block_id=0, tgt_inst_id=0.
- LOCAL_RACK_ID=2, addr 0x5400000 (ZAP MEM, rack 5) → tgt_class=4, tgt_zap_id=40, tgt_offset=0.
- Back-to-back stream of 8 valid requests, tgt_ready low for 3 cycles mid-stream → req_ready low exactly those cycles, outputs held stable, all 8 delivered in order with no loss or duplication.
- Assert rst while tgt_valid=1 and tgt_ready=0 → next cycle tgt_valid=0 and err_valid=0; after rst drops, req_ready=1 and the held entry never appears.
